fifo: RTL and testbench
=======================

Name: fifo

Overview:
- Synchronous single-clock FIFO: 4 words deep, 8 bits wide.
- First-word-fall-through read: `data_out` always presents the oldest stored word.
- Status outputs `full` and `empty` let the producer and consumer gate their requests.
- Used as a small rate-decoupling buffer between two blocks in the same clock domain.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, number of storage words; must be a power of two.
- ADDR_W, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- data_in  input  WIDTH  write data, sampled on the rising clk edge when a write is accepted.
- wr_en  input  1  write request.
- rd_en  input  1  read (pop) request.
- data_out  output  WIDTH  word at the read pointer (head of queue).
- full  output  1  high when word_count == DEPTH.
- empty  output  1  high when word_count == 0.

Behaviour:
- Internal state, accessible by hierarchical name for bench inspection:
  - `wr_pointer` [ADDR_W-1:0]
  - `rd_pointer` [ADDR_W-1:0]
  - `word_count` [ADDR_W:0], range 0..DEPTH
  - storage in a submodule instance named `mem1` holding array `mem[0:DEPTH-1]` of WIDTH bits. `mem1` has a synchronous write port (we, waddr, wdata) and a combinational read port (raddr, rdata).
- Reset (rst_n low, asynchronous, any time including mid-operation):
  - `wr_pointer`, `rd_pointer` and `word_count` go to 0.
  - All `mem` entries clear to 0.
  - Resulting outputs: `empty`=1, `full`=0, `data_out`=0.
  - Normal operation resumes on the first rising edge after rst_n goes high.
- Write accept condition: wr_en & ~full.
  - At the rising edge, `mem[wr_pointer]` <= `data_in`.
  - `wr_pointer` increments modulo DEPTH (3 -> 0 wrap).
- Read accept condition: rd_en & ~empty.
  - At the rising edge, `rd_pointer` increments modulo DEPTH.
  - The popped word is the value on `data_out` during the cycle before that edge.
- Read latency and data path:
  - `data_out` = `mem[rd_pointer]`, combinational.
  - Zero-cycle read latency (FWFT).
  - A word written at edge N appears on `data_out` after edge N if the FIFO was empty.
- `word_count` update each edge:
  - +1 on write-only accept.
  - -1 on read-only accept.
  - Unchanged on simultaneous accepts or when nothing is accepted.
- Flags:
  - `full` and `empty` decode combinationally from `word_count`; no extra latency.
  - Both are valid in the same cycle as the new count.
- Overflow: wr_en while full is ignored. No state change and no data corruption, even if rd_en is also high that cycle. The read still proceeds.
- Underflow: rd_en while empty is ignored. Pointers are unchanged and `data_out` is don't-care (stale `mem` content). A simultaneous write still proceeds.
- Simultaneous accepted read and write when 0 < count < DEPTH:
  - Both pointers advance.
  - `word_count` is unchanged.
  - The write never disturbs the word being read, because the pointers differ.
- Ordering: strict first-in first-out. The data sequence read out equals the accepted write sequence.
- No assertions or error outputs; illegal requests are silently dropped.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 asynchronously, mid-cycle, with the FIFO holding 2 words.
  - Required: immediately `empty`=1, `full`=0, both pointers 0, `word_count`=0.
- Fill:
  - Stimulus: write 0x11,0x22,0x33,0x44 on 4 consecutive edges with rd_en=0.
  - Required: `full`=1 after the 4th edge, `word_count`=4, `wr_pointer`=0 (wrapped), `data_out`=0x11.
- Overflow:
  - Stimulus: when full, wr_en=1 with `data_in`=0x55.
  - Required: `mem` unchanged, `word_count` stays 4.
  - Then stimulus: 4 reads.
  - Required: read data 0x11,0x22,0x33,0x44; `empty`=1 afterwards; a 5th rd_en is ignored with `rd_pointer` unchanged.
- Simultaneous read/write:
  - Stimulus: with 2 words stored, wr_en=rd_en=1 for 3 edges.
  - Required: `word_count` stays 2, both pointers advance by 3 modulo 4, FIFO order preserved.
- Boundary cases:
  - Stimulus: empty FIFO with wr_en=rd_en=1 in the same cycle.
  - Required: only the write is accepted, `word_count`=1.
  - Stimulus: full FIFO with wr_en=rd_en=1 in the same cycle.
  - Required: only the read is accepted, `word_count`=3.
- Random soak:
  - Stimulus: 100 cycles of random data with wr_en gated by ~full and rd_en gated by ~empty.
  - Required: the logged read sequence equals a prefix of the logged write sequence.

Source files
------------

// File: rtl/fifo.sv
// ---------------------------------------------------------------------------
// fifo : 4-word x 8-bit synchronous single-clock FIFO, first-word-fall-through.
//
// The oldest stored word is always visible on data_out, so a consumer can
// look at the head of the queue before deciding to pop it. Used as a small
// rate-decoupling buffer between two blocks in the same clock domain.
//
// Ports
//   clk      in   1      system clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   data_in  in   WIDTH  write data, captured when a write is accepted
//   wr_en    in   1      write request (ignored while full)
//   rd_en    in   1      pop request (ignored while empty)
//   data_out out  WIDTH  word at the head of the queue
//   full     out  1      word_count == DEPTH
//   empty    out  1      word_count == 0
// ---------------------------------------------------------------------------

// Storage array: synchronous write port, combinational read port.
// Every entry clears on reset so data_out reads 0 straight out of reset.
module fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  // Write port; the reset clears the whole array, not just the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port is asynchronous, which gives the zero-latency head view.
  assign rdata = mem[raddr];

endmodule

module fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_pointer;
  logic [ADDR_W-1:0] rd_pointer;
  logic [ADDR_W:0]   word_count;

  logic w_wrAccept;
  logic w_rdAccept;

  // Requests against the wrong flag are dropped here, so nothing downstream
  // ever sees an overflowing write or an underflowing read.
  assign full       = (word_count == COUNT_FULL);
  assign empty      = (word_count == '0);
  assign w_wrAccept = wr_en & ~full;
  assign w_rdAccept = rd_en & ~empty;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) mem1 (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (w_wrAccept),
    .waddr(wr_pointer),
    .wdata(data_in),
    .raddr(rd_pointer),
    .rdata(data_out)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pointer <= '0;
      rd_pointer <= '0;
    end else begin
      if (w_wrAccept) wr_pointer <= wr_pointer + 1'b1;
      if (w_rdAccept) rd_pointer <= rd_pointer + 1'b1;
    end
  end

  // Occupancy only moves when exactly one side is accepted; a simultaneous
  // push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
    end else begin
      case ({w_wrAccept, w_rdAccept})
        2'b10:   word_count <= word_count + 1'b1;
        2'b01:   word_count <= word_count - 1'b1;
        default: word_count <= word_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo.sv
// ---------------------------------------------------------------------------
// tb_fifo : self-checking bench for fifo.
// A queue holds every word the bench expects to read back; it is pushed when
// a write should be accepted and popped/compared when a read should be.
// Occupancy and pointers are tracked by an independent model.
// ---------------------------------------------------------------------------
module tb_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int checkCount;
  int errorCount;

  logic [7:0] expQueue [$];
  int         modelCount;
  logic [1:0] modelWr;
  logic [1:0] modelRd;

  fifo dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .data_out(data_out),
    .full    (full),
    .empty   (empty)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of requests (called just after a rising edge). The head
  // word is checked at the falling edge, before the edge that pops it; state
  // is checked just after the rising edge.
  task automatic applyStimulus(input logic w, input logic r, input logic [7:0] d);
    logic wAcc;
    logic rAcc;
    logic [7:0] expWord;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    wAcc = w && (modelCount != 4);
    rAcc = r && (modelCount != 0);
    @(negedge clk);
    if (rAcc) begin
      expWord = expQueue.pop_front();
      checkOutput("read_data", 32'(data_out), 32'(expWord));
    end
    if (wAcc) expQueue.push_back(d);
    if (wAcc && !rAcc) modelCount++;
    if (rAcc && !wAcc) modelCount--;
    if (wAcc) modelWr = modelWr + 2'd1;
    if (rAcc) modelRd = modelRd + 2'd1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    checkOutput("word_count", 32'(dut.word_count), 32'(modelCount));
    checkOutput("full",       32'(full),  32'(modelCount == 4));
    checkOutput("empty",      32'(empty), 32'(modelCount == 0));
    checkOutput("wr_pointer", 32'(dut.wr_pointer), 32'(modelWr));
    checkOutput("rd_pointer", 32'(dut.rd_pointer), 32'(modelRd));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_empty"}, 32'(empty), 32'd1);
    checkOutput({tag, "_full"},  32'(full),  32'd0);
    checkOutput({tag, "_count"}, 32'(dut.word_count), 32'd0);
    checkOutput({tag, "_wrptr"}, 32'(dut.wr_pointer), 32'd0);
    checkOutput({tag, "_rdptr"}, 32'(dut.rd_pointer), 32'd0);
    checkOutput({tag, "_dout"},  32'(data_out), 32'd0);
  endtask

  task automatic clearModel();
    expQueue.delete();
    modelCount = 0;
    modelWr    = 2'd0;
    modelRd    = 2'd0;
  endtask

  initial begin
    logic [7:0] fillData [4];
    checkCount = 0;
    errorCount = 0;
    clearModel();
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 8'h00;

    // Power-on reset, released away from a clock edge.
    #22;
    checkResetState("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two words stored, then an asynchronous reset in the middle of a cycle.
    applyStimulus(1'b1, 1'b0, 8'hA1);
    applyStimulus(1'b1, 1'b0, 8'hA2);
    checkOutput("pre_reset_count", 32'(dut.word_count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("midrst");
    clearModel();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full; write pointer wraps back to 0, head is the first word.
    fillData = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, fillData[i]);
    checkOutput("fill_head", 32'(data_out), 32'h11);

    // Overflow write is dropped; storage untouched.
    applyStimulus(1'b1, 1'b0, 8'h55);
    for (int i = 0; i < 4; i++) begin
      checkOutput("ovf_mem", 32'(dut.mem1.mem[i]), 32'(fillData[i]));
    end

    // Drain in order, then an underflowing read.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00);

    // Empty with read+write: only the write lands.
    applyStimulus(1'b1, 1'b1, 8'h66);
    checkOutput("empty_rw_head", 32'(data_out), 32'h66);

    // Two stored, three simultaneous read/write cycles.
    applyStimulus(1'b1, 1'b0, 8'h77);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'h81 + 8'(i));

    // Top up to full, then read+write while full: only the read lands.
    applyStimulus(1'b1, 1'b0, 8'h91);
    applyStimulus(1'b1, 1'b0, 8'h92);
    applyStimulus(1'b1, 1'b1, 8'hEE);

    // Drain what remains.
    while (modelCount > 0) applyStimulus(1'b0, 1'b1, 8'h00);

    // Random soak with requests gated by the flags.
    for (int i = 0; i < 100; i++) begin
      logic w;
      logic r;
      w = ($urandom_range(0, 1) == 1) && !full;
      r = ($urandom_range(0, 1) == 1) && !empty;
      applyStimulus(w, r, 8'($urandom_range(0, 255)));
    end
    while (modelCount > 0) applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("soak_leftover", 32'(expQueue.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
